alu_arbiter: RTL and testbench

//   Shares one 4-bit ALU between two requesters with valid/ready handshakes.

---
 rtl/alu_arbiter.sv | 120 ++++++++++++
 tb/tb_alu_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// ============================================================================
// Module  : alu_arbiter
// Brief   : Round-robin arbiter sharing one registered-input ALU between two
//           valid/ready requesters, with per-requester response channels.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_arbiter #(
  parameter int DW  = 4,
  parameter int OPW = 2,
  parameter int RW  = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [DW-1:0]  req0_a,
  input  logic [DW-1:0]  req0_b,
  input  logic [OPW-1:0] req0_op,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [DW-1:0]  req1_a,
  input  logic [DW-1:0]  req1_b,
  input  logic [OPW-1:0] req1_op,
  output logic           rsp0_valid,
  input  logic           rsp0_ready,
  output logic [RW-1:0]  rsp0_y,
  output logic           rsp1_valid,
  input  logic           rsp1_ready,
  output logic [RW-1:0]  rsp1_y,
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  output logic [OPW-1:0] alu_op,
  input  logic [RW-1:0]  alu_y
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic           r_last_grant;
  logic           r_gnt;
  logic [DW-1:0]  r_alu_a;
  logic [DW-1:0]  r_alu_b;
  logic [OPW-1:0] r_alu_op;
  logic [RW-1:0]  r_result;

  logic           w_grant0;
  logic           w_grant1;
  logic           w_xfer;
  logic           w_rsp_ready;

  // On contention the requester that was not served last wins.
  assign w_grant0    = req0_valid & (~req1_valid | r_last_grant);
  assign w_grant1    = req1_valid & (~req0_valid | ~r_last_grant);
  assign w_xfer      = (r_state == S_IDLE) & (req0_valid | req1_valid);
  assign w_rsp_ready = r_gnt ? rsp1_ready : rsp0_ready;

  assign req0_ready  = ~rst & (r_state == S_IDLE) & w_grant0;
  assign req1_ready  = ~rst & (r_state == S_IDLE) & w_grant1;

  assign rsp0_valid  = (r_state == S_RESP) & ~r_gnt;
  assign rsp1_valid  = (r_state == S_RESP) & r_gnt;
  assign rsp0_y      = rsp0_valid ? r_result : '0;
  assign rsp1_y      = rsp1_valid ? r_result : '0;

  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_op      = r_alu_op;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_xfer) w_state_nxt = S_EXEC;
      S_EXEC:  w_state_nxt = S_RESP;
      S_RESP:  if (w_rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= 1'b1;
      r_gnt        <= 1'b0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_op     <= '0;
      r_result     <= '0;
    end else begin
      if (w_xfer) begin
        r_gnt    <= w_grant1;
        r_alu_a  <= w_grant1 ? req1_a  : req0_a;
        r_alu_b  <= w_grant1 ? req1_b  : req0_b;
        r_alu_op <= w_grant1 ? req1_op : req0_op;
      end
      if (r_state == S_EXEC) begin
        r_result <= alu_y;
      end
      if ((r_state == S_RESP) && w_rsp_ready) begin
        r_last_grant <= r_gnt;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// Module  : tb_alu_arbiter
// Brief   : Scoreboard bench for alu_arbiter with a behavioural ALU and
//           a queue-based round-robin reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_arbiter;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    logic [7:0] y;
  } item_t;

  logic       clk;
  logic       rst;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0] req0_op, req1_op;
  logic       rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [7:0] rsp0_y, rsp1_y;
  logic [3:0] alu_a, alu_b;
  logic [1:0] alu_op;
  logic [7:0] alu_y;

  item_t q0[$];
  item_t q1[$];
  int    n_chk  = 0;
  int    n_fail = 0;
  int    cyc    = 0;
  bit    busy   = 1'b0;
  bit    inflight = 1'b0;
  bit    model_last = 1'b1;
  int    acc    = 0;

  alu_arbiter #(.DW(4), .OPW(2), .RW(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_y(rsp0_y),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_y(rsp1_y),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_y(alu_y)
  );

  // 4-bit operands zero-extended to 8 bits; SUB and NOT wrap in 8 bits.
  function automatic logic [7:0] alu_ref(input logic [1:0] op, input logic [3:0] a,
                                         input logic [3:0] b);
    logic [7:0] ea;
    logic [7:0] eb;
    ea = {4'b0, a};
    eb = {4'b0, b};
    case (op)
      2'd0:    return ea + eb;
      2'd1:    return ea - eb;
      2'd2:    return ~ea;
      default: return ea & eb;
    endcase
  endfunction

  always_comb alu_y = alu_ref(alu_op, alu_a, alu_b);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard: reference arbitration model and response checking.
  initial begin
    bit         g, e0, e1, ev0, ev1, pv0, pv1, gv, gr;
    logic [7:0] py0, py1, gy;
    item_t      it;
    pv0 = 1'b0; pv1 = 1'b0; py0 = '0; py1 = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_req_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
        chk("rst_rsp_valid", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
        chk("rst_rsp_y", {16'd0, rsp0_y, rsp1_y}, 32'd0);
        chk("rst_alu_regs", {22'd0, alu_a, alu_b, alu_op}, 32'd0);
        if (busy) begin
          if (inflight && q1.size() > 0) void'(q1.pop_front());
          if (!inflight && q0.size() > 0) void'(q0.pop_front());
        end
        busy = 1'b0;
        model_last = 1'b1;
        pv0 = 1'b0;
        pv1 = 1'b0;
      end else begin
        g   = (req0_valid && req1_valid) ? ~model_last : !req0_valid;
        e0  = !busy && req0_valid && !g;
        e1  = !busy && req1_valid && g;
        chk("req_ready", {30'd0, req0_ready, req1_ready}, {30'd0, e0, e1});
        ev0 = busy && !inflight && (cyc >= acc + 2);
        ev1 = busy && inflight && (cyc >= acc + 2);
        chk("rsp_valid", {30'd0, rsp0_valid, rsp1_valid}, {30'd0, ev0, ev1});
        if (!rsp0_valid) chk("rsp0_y_idle", {24'd0, rsp0_y}, 32'd0);
        if (!rsp1_valid) chk("rsp1_y_idle", {24'd0, rsp1_y}, 32'd0);
        if (pv0 && rsp0_valid) chk("rsp0_y_stable", {24'd0, rsp0_y}, {24'd0, py0});
        if (pv1 && rsp1_valid) chk("rsp1_y_stable", {24'd0, rsp1_y}, {24'd0, py1});
        pv0 = rsp0_valid && !rsp0_ready;
        pv1 = rsp1_valid && !rsp1_ready;
        py0 = rsp0_y;
        py1 = rsp1_y;
        if (busy && (cyc >= acc + 2)) begin
          gv = inflight ? rsp1_valid : rsp0_valid;
          gr = inflight ? rsp1_ready : rsp0_ready;
          gy = inflight ? rsp1_y : rsp0_y;
          if (gv && gr) begin
            if ((inflight ? q1.size() : q0.size()) == 0) begin
              chk("rsp_unexpected", 32'd1, 32'd0);
            end else begin
              it = inflight ? q1.pop_front() : q0.pop_front();
              chk(inflight ? "rsp1_y" : "rsp0_y", {24'd0, gy}, {24'd0, it.y});
              chk("alu_operands", {22'd0, alu_a, alu_b, alu_op},
                  {22'd0, it.a, it.b, it.op});
            end
            model_last = inflight;
            busy = 1'b0;
          end
        end
        if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
          busy     = 1'b1;
          inflight = !(req0_valid && req0_ready);
          acc      = cyc;
        end
      end
    end
  end

  // Advance one cycle; drop a request's valid once it has transferred.
  task automatic tick();
    bit a0, a1;
    @(negedge clk);
    a0 = req0_valid && req0_ready;
    a1 = req1_valid && req1_ready;
    @(posedge clk);
    #1;
    if (a0) req0_valid = 1'b0;
    if (a1) req1_valid = 1'b0;
  endtask

  task automatic issue(input bit p, input logic [1:0] op, input logic [3:0] a,
                       input logic [3:0] b, input logic [7:0] y);
    item_t it;
    it = '{a: a, b: b, op: op, y: y};
    if (!p) begin
      req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
      q0.push_back(it);
    end else begin
      req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
      q1.push_back(it);
    end
  endtask

  task automatic issue_rand(input bit p);
    logic [1:0] op;
    logic [3:0] a, b;
    op = 2'($urandom_range(0, 3));
    a  = 4'($urandom_range(0, 15));
    b  = 4'($urandom_range(0, 15));
    issue(p, op, a, b, alu_ref(op, a, b));
  endtask

  task automatic wait_idle();
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < 200) begin
      tick();
      n++;
      done = !req0_valid && !req1_valid && !busy && q0.size() == 0 && q1.size() == 0;
    end
    chk("drain_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  initial begin
    int n0, n1, guard;
    rst = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Single ADD on requester 0
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    issue(1'b0, 2'd0, 4'd9, 4'd8, 8'h11);
    wait_idle();

    // Contention straight after reset: requester 0 wins first
    do_reset();
    issue(1'b0, 2'd1, 4'd3, 4'd5, 8'hFE);
    issue(1'b1, 2'd3, 4'hF, 4'h6, 8'h06);
    wait_idle();

    // Both held valid for four operations: grants alternate
    n0 = 0; n1 = 0; guard = 0;
    while ((n0 < 2 || n1 < 2 || req0_valid || req1_valid) && guard < 100) begin
      if (!req0_valid && n0 < 2) begin issue_rand(1'b0); n0++; end
      if (!req1_valid && n1 < 2) begin issue_rand(1'b1); n1++; end
      tick();
      guard++;
    end
    wait_idle();

    // Response back-pressure on requester 1 while requester 0 waits
    rsp1_ready = 1'b0;
    issue(1'b1, 2'd2, 4'd5, 4'd0, 8'hFA);
    tick();
    issue(1'b0, 2'd3, 4'd7, 4'd3, 8'h03);
    repeat (7) tick();
    rsp1_ready = 1'b1;
    wait_idle();

    // Reset during EXEC discards the in-flight operation
    issue(1'b0, 2'd0, 4'd1, 4'd2, 8'h03);
    tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    issue(1'b0, 2'd0, 4'd2, 4'd2, 8'h04);
    wait_idle();

    // Randomized traffic with random response back-pressure
    for (int i = 0; i < 400; i++) begin
      rsp0_ready = 1'($urandom_range(0, 1));
      rsp1_ready = 1'($urandom_range(0, 1));
      if (!req0_valid && $urandom_range(0, 2) == 0) issue_rand(1'b0);
      if (!req1_valid && $urandom_range(0, 2) == 0) issue_rand(1'b1);
      tick();
    end
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    wait_idle();

    chk("queues_empty", q0.size() + q1.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
